ffm: RTL and testbench
======================

# ffm

Bit-serial modular multiplier over GF(p), p = 2^255 − 19, for the scalar-multiplication datapath. It consumes operands produced by the field adder and computes out = a_i · b_i mod p using MSB-first interleaved double-and-add reduction. Each iteration takes one cycle, and the result is held on `out` until the next operation completes.

## Interface
Parameters:
- `P`, default 2^255 − 19 (256-bit). Field modulus; the value is fixed for this design.
- `N`, default 255. Operand width in bits, which is also the iteration count.

Ports:
- `clk`, input, 1. The block's single clock. All state changes on the rising edge.
- `rst`, input, 1. Asynchronous, active-low reset.
- `start`, input, 1. Request pulse. Sampled only in IDLE.
- `a_i`, input, 255. Multiplier. Must be < p.
- `b_i`, input, 255. Multiplicand. Must be < p.
- `out`, output, 255. Product mod p. Registered.
- `done`, output, 1. One-cycle pulse when `out` is updated.
- `busy`, output, 1. High while an operation is in progress.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: performs the iterations.
- Registers:
  - A and B (255 b each): captured operands.
  - R (256 b): accumulator.
  - i (8 b): bit index.
- IDLE with `start`=1 on an edge:
  - capture A←a_i and B←b_i;
  - clear R←0 and set i←254;
  - set busy←1 and go to RUN.
  - `start`=0 in IDLE: stay in IDLE, no change.
- RUN, per edge:
  - t = 2R; if t ≥ p then t −= p.
  - u = A[i] ? t + B : t; if u ≥ p then u −= p.
  - Write R←u and decrement i.
  - R < p and B < p, so each step needs at most one subtraction. Intermediates are 257 bits wide.
- RUN edge that processes i = 0:
  - out←u, done←1, busy←0;
  - go to IDLE.
- `start` is ignored while in RUN. Operands are held internally, so a_i and b_i may change after capture.
- Results are fully reduced to [0, p−1] for legal inputs. Behaviour for inputs ≥ p is undefined.
- Reset, asserted at any time including mid-RUN:
  - state←IDLE;
  - out←0, done←0, busy←0;
  - R, A, B, i←0.
  - The in-flight operation is discarded and no `done` is produced.

## Timing
- `start` sampled at edge E:
  - `busy` is high from E to E+255;
  - `done` is high for exactly the cycle between E+255 and E+256;
  - `out` is valid from E+255 and stable until the next completion.
- Latency is 255 cycles from the accepting edge to `done`.
- `done` is a registered single-cycle pulse. It is cleared on every edge where it is not being set.
- Back-to-back operation:
  - `start` high during the `done` cycle is accepted at E+256, because the block is already in IDLE.
  - Peak throughput is one product per 256 cycles.
- `out` is not changed by accepting a new `start`. It changes only at completion or reset.
- Reset release: the first edge with `rst`=1 may accept `start`.

## Test plan
- a_i=1, b_i=1, pulse `start` → after exactly 255 cycles `done`=1 for one cycle and out=1; `busy` falls on the same edge.
- a_i=2^254, b_i=2 → out=19. a_i=p−1, b_i=p−1 → out=1. a_i=121666, b_i=9 → out=1094994.
- a_i=0, b_i=p−1 → out=0. a_i=p−1, b_i=0 → out=0.
- `start` pulses at cycles 10 and 100 of a busy operation, with a_i and b_i changed after capture → the single `done` carries the original product, and no second operation starts.
- Assert `rst` low at cycle 120 of RUN → out=0, done=0, busy=0 immediately. No `done` appears afterwards. A new `start` after release gives a correct result.
- Hold `start`=1 continuously with different operands sampled at the accept edges → `done` pulses exactly every 256 cycles, and each `out` matches its own operand pair per a golden model.

Source files
------------

// File: rtl/ffm.sv
// Bit-serial GF(p) multiplier, p = 2^255 - 19, MSB-first interleaved double-and-add.
// One multiplier bit is consumed per cycle; the result is held on out until the next completion.
module ffm #(
    parameter logic [255:0] P = (256'd1 << 255) - 256'd19,
    parameter int           N = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] out,
    output logic         done,
    output logic         busy
);

    localparam int IW = $clog2(N);
    localparam logic [N+1:0] P_EXT = (N+2)'(P);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, b_q;
    logic [N:0]     r_q;
    logic [IW-1:0]  idx;

    logic [N+1:0]   t_raw, t_red, u_raw;
    logic [N:0]     u_red;

    // R < p and B < p keep each step within a single conditional subtraction
    always_comb begin
        t_raw = {r_q, 1'b0};
        t_red = (t_raw >= P_EXT) ? t_raw - P_EXT : t_raw;
        u_raw = a_q[idx] ? t_red + {2'b00, b_q} : t_red;
        u_red = (N+1)'((u_raw >= P_EXT) ? u_raw - P_EXT : u_raw);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q  <= '0;
            b_q  <= '0;
            r_q  <= '0;
            idx  <= '0;
            out  <= '0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q  <= a_i;
                        b_q  <= b_i;
                        r_q  <= '0;
                        idx  <= IW'(N-1);
                        busy <= 1'b1;
                    end
                end
                RUN: begin
                    r_q <= u_red;
                    idx <= idx - IW'(1);
                    if (idx == '0) begin
                        out  <= u_red[N-1:0];
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ffm.sv
// Directed bench for ffm: hand-computed products, latency, start-ignore, mid-run reset
// and back-to-back throughput.
module tb_ffm;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [254:0] a_i = '0;
    logic [254:0] b_i = '0;
    logic [254:0] out;
    logic         done, busy;

    int vectors = 0;
    int errors  = 0;

    logic [254:0] pm1, p2_254, p2_128, p2_127;
    logic [254:0] ba[4], bb[4], be[4];
    int n, cnt_done, cnt_busy;

    always #5 clk = ~clk;

    ffm dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a_i  (a_i),
        .b_i  (b_i),
        .out  (out),
        .done (done),
        .busy (busy)
    );

    task automatic check(input string tag, input logic [254:0] obs, input logic [254:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!done && cycles < 300);
    endtask

    task automatic run_op(input string tag, input logic [254:0] a, input logic [254:0] b,
                          input logic [254:0] exp);
        int c;
        a_i = a; b_i = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_hi"}, 255'(busy), 255'd1);
        wait_done(c);
        check({tag, "_latency"}, 255'(c), 255'd255);
        check({tag, "_out"}, out, exp);
        check({tag, "_busy_lo"}, 255'(busy), 255'd0);
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, 255'(done), 255'd0);
        check({tag, "_out_hold"}, out, exp);
    endtask

    initial begin
        pm1 = '1;
        pm1 = pm1 - 255'd19;
        p2_254 = 255'd1 << 254;
        p2_128 = 255'd1 << 128;
        p2_127 = 255'd1 << 127;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out",  out, '0);
        check("rst_done", 255'(done), 255'd0);
        check("rst_busy", 255'(busy), 255'd0);
        rst = 1'b1;

        run_op("one",      255'd1,      255'd1,   255'd1);
        run_op("wrap19",   p2_254,      255'd2,   255'd19);
        run_op("pm1sq",    pm1,         pm1,      255'd1);
        run_op("a24",      255'd121666, 255'd9,   255'd1094994);
        run_op("zero_a",   255'd0,      pm1,      255'd0);
        run_op("zero_b",   pm1,         255'd0,   255'd0);

        // start pulses during RUN and operand changes after capture are ignored
        a_i = 255'd3; b_i = 255'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_i = pm1; b_i = 255'd2;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            start = (n == 10 || n == 100);
            if (start) begin a_i = a_i - 255'd1; b_i = b_i + 255'd1; end
        end while (!done && n < 300);
        start = 1'b0;
        check("ign_latency", 255'(n), 255'd255);
        check("ign_out", out, 255'd15);
        cnt_done = 0; cnt_busy = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (done) cnt_done++;
            if (busy) cnt_busy++;
        end
        check("ign_no_2nd_done", 255'(cnt_done), 255'd0);
        check("ign_no_2nd_busy", 255'(cnt_busy), 255'd0);

        // asynchronous reset mid-RUN
        a_i = 255'd121666; b_i = 255'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (120) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mrst_out",  out, '0);
        check("mrst_done", 255'(done), 255'd0);
        check("mrst_busy", 255'(busy), 255'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cnt_done = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (done) cnt_done++;
        end
        check("mrst_no_done", 255'(cnt_done), 255'd0);
        check("mrst_out_kept", out, '0);
        run_op("post_rst", pm1, 255'd2, pm1 - 255'd1);

        // back-to-back with start held high
        ba[0] = 255'd3;  bb[0] = 255'd5;   be[0] = 255'd15;
        ba[1] = p2_254;  bb[1] = 255'd4;   be[1] = 255'd38;
        ba[2] = pm1;     bb[2] = 255'd2;   be[2] = pm1 - 255'd1;
        ba[3] = p2_128;  bb[3] = p2_127;   be[3] = 255'd19;
        a_i = ba[0]; b_i = bb[0]; start = 1'b1;
        @(posedge clk); #1;
        a_i = ba[1]; b_i = bb[1];
        for (int k = 0; k < 4; k++) begin
            wait_done(n);
            check($sformatf("b2b%0d_latency", k), 255'(n), 255'd255);
            check($sformatf("b2b%0d_out", k), out, be[k]);
            @(posedge clk); #1;
            check($sformatf("b2b%0d_done_clr", k), 255'(done), 255'd0);
            check($sformatf("b2b%0d_busy", k), 255'(busy), (k < 3) ? 255'd1 : 255'd0);
            if (k + 2 < 4) begin a_i = ba[k+2]; b_i = bb[k+2]; end
            if (k == 2) start = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
